cache_miss_ctrl: RTL

- Sequencing controller for the 4-way set-associative cache (7-bit address, 4 sets).
- Accepts one CPU read/write request at a time and runs the tag lookup.
- Chooses the victim way from per-set age-based LRU state it holds, and performs dirty-victim writeback and line refill through a RAM handshake.
- Issues the one-hot per-way cache write enables and the RAM write/read strobes.

---
 rtl/cache_miss_ctrl_if.sv | 51 +++++
 rtl/cache_miss_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl_if.sv
// cache_miss_ctrl_if: bundles the CPU request handshake, the cache-array lookup/write
// signals and the RAM transfer handshake of cache_miss_ctrl.
//
// Modports:
//   master - the controller's view: it samples the CPU request and the indexed-set
//            state, and drives the cache write enables and the RAM strobes.
//   slave  - the environment's view (CPU, cache arrays, RAM), directions mirrored.
//
// Signals:
//   cpu_req, cpu_wren, cpu_addr   CPU request, write flag and address
//   cpu_ready, cpu_done           controller idle / one-cycle completion pulse
//   look_addr                     registered request address to the cache arrays
//   hit, valido, dirty, way_tag   lookup results for the indexed set
//   wren_cache, fill_sel          one-hot way write enable, write data source select
//   ram_wren, ram_rden, ram_addr  RAM strobes and address
//   ram_ack                       RAM transfer complete
interface cache_miss_ctrl_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WAYS   = 4
);
  localparam int unsigned TAG_W = ADDR_W - 2;

  logic                    cpu_req;
  logic                    cpu_wren;
  logic [ADDR_W-1:0]       cpu_addr;
  logic                    cpu_ready;
  logic                    cpu_done;
  logic [ADDR_W-1:0]       look_addr;
  logic [WAYS-1:0]         hit;
  logic [WAYS-1:0]         valido;
  logic [WAYS-1:0]         dirty;
  logic [WAYS*TAG_W-1:0]   way_tag;
  logic [WAYS-1:0]         wren_cache;
  logic                    fill_sel;
  logic                    ram_wren;
  logic                    ram_rden;
  logic [ADDR_W-1:0]       ram_addr;
  logic                    ram_ack;

  modport master (
    input  cpu_req, cpu_wren, cpu_addr, hit, valido, dirty, way_tag, ram_ack,
    output cpu_ready, cpu_done, look_addr, wren_cache, fill_sel, ram_wren, ram_rden,
           ram_addr
  );

  modport slave (
    output cpu_req, cpu_wren, cpu_addr, hit, valido, dirty, way_tag, ram_ack,
    input  cpu_ready, cpu_done, look_addr, wren_cache, fill_sel, ram_wren, ram_rden,
           ram_addr
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: sequencing controller for a 4-way set-associative cache with a 7-bit
// address (tag = addr[6:2], index = addr[1:0], 4 sets).
//
// Takes one CPU request at a time, runs the tag lookup, picks a victim way from per-set
// age-based LRU state, performs dirty-victim writeback and line refill over a RAM
// strobe/ack handshake, and issues the one-hot cache way write enables.
//
// Build option:
//   WRITE_BACK_EN defined   - write-back, write-allocate (dirty victims go through WB)
//   WRITE_BACK_EN undefined - write-through, write-allocate (every write goes through
//                             WTHRU; the dirty input is ignored)
//
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     cache_miss_ctrl_if.master (CPU, cache-array and RAM signals)
module cache_miss_ctrl #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WAYS   = 4
) (
  input logic               clock,
  input logic               resetn,
  cache_miss_ctrl_if.master bus
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned SETS  = 4;
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam int unsigned AGE_W = 2;

`ifdef WRITE_BACK_EN
  localparam bit WriteBack = 1'b1;
`else
  localparam bit WriteBack = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWb,
    StRefill,
    StWthru,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   look_addr_q, look_addr_d;
  logic                wr_q, wr_d;
  logic [WAYS-1:0]     tgt_q, tgt_d;        // way written/touched by this transaction
  logic [TAG_W-1:0]    vtag_q, vtag_d;      // victim tag captured for the writeback address
  logic [AGE_W-1:0]    age_q [SETS][WAYS];
  logic [AGE_W-1:0]    age_d [SETS][WAYS];

  logic [IDX_W-1:0]    idx;
  logic [WAYS-1:0]     hit_oh;
  logic [WAYS-1:0]     inv_oh;
  logic [WAYS-1:0]     lru_oh;
  logic [WAYS-1:0]     victim_oh;
  logic [TAG_W-1:0]    victim_tag;
  logic                victim_dirty;
  logic [AGE_W-1:0]    tgt_age;

  assign idx           = look_addr_q[IDX_W-1:0];
  assign bus.look_addr = look_addr_q;

  // Lookup decode: lowest hit bit wins; victim is the lowest invalid way, else the
  // oldest (age WAYS-1) way of the set.
  always_comb begin
    hit_oh = '0;
    inv_oh = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit[i]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
      if (!bus.valido[i]) begin
        inv_oh    = '0;
        inv_oh[i] = 1'b1;
      end
    end
    lru_oh = '0;
    for (int i = 0; i < WAYS; i++) begin
      lru_oh[i] = (age_q[idx][i] == AGE_W'(WAYS - 1));
    end
    victim_oh  = (|inv_oh) ? inv_oh : lru_oh;
    victim_tag = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (victim_oh[i]) begin
        victim_tag = bus.way_tag[i*TAG_W +: TAG_W];
      end
    end
    victim_dirty = WriteBack && (|(victim_oh & bus.valido & bus.dirty));
  end

  // Main FSM next-state and outputs.
  always_comb begin
    state_d        = state_q;
    look_addr_d    = look_addr_q;
    wr_d           = wr_q;
    tgt_d          = tgt_q;
    vtag_d         = vtag_q;
    bus.cpu_ready  = 1'b0;
    bus.cpu_done   = 1'b0;
    bus.wren_cache = '0;
    bus.fill_sel   = 1'b0;
    bus.ram_wren   = 1'b0;
    bus.ram_rden   = 1'b0;
    bus.ram_addr   = '0;

    unique case (state_q)
      StIdle: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_req) begin
          look_addr_d = bus.cpu_addr;
          wr_d        = bus.cpu_wren;
          state_d     = StLookup;
        end
      end

      StLookup: begin
        if (|bus.hit) begin
          tgt_d   = hit_oh;
          state_d = (!WriteBack && wr_q) ? StWthru : StResp;
        end else begin
          tgt_d   = victim_oh;
          vtag_d  = victim_tag;
          state_d = victim_dirty ? StWb : StRefill;
        end
      end

      StWb: begin
        bus.ram_wren = 1'b1;
        bus.ram_addr = {vtag_q, idx};
        if (bus.ram_ack) begin
          state_d = StRefill;
        end
      end

      StRefill: begin
        bus.ram_rden = 1'b1;
        bus.ram_addr = look_addr_q;
        if (bus.ram_ack) begin
          // Line data is on the RAM bus this cycle; write it into the victim way.
          bus.wren_cache = tgt_q;
          bus.fill_sel   = 1'b1;
          state_d        = (!WriteBack && wr_q) ? StWthru : StResp;
        end
      end

      StWthru: begin
        bus.ram_wren = 1'b1;
        bus.ram_addr = look_addr_q;
        if (bus.ram_ack) begin
          state_d = StResp;
        end
      end

      StResp: begin
        bus.cpu_done = 1'b1;
        if (wr_q) begin
          bus.wren_cache = tgt_q;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // LRU ages: touching a way zeroes its age and ages every younger way by one, so the
  // set stays a permutation of 0..WAYS-1.
  always_comb begin
    age_d   = age_q;
    tgt_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (tgt_q[w]) begin
        tgt_age = age_q[idx][w];
      end
    end
    if (state_q == StResp) begin
      for (int w = 0; w < WAYS; w++) begin
        if (tgt_q[w]) begin
          age_d[idx][w] = '0;
        end else if (age_q[idx][w] < tgt_age) begin
          age_d[idx][w] = age_q[idx][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      look_addr_q <= '0;
      wr_q        <= 1'b0;
      tgt_q       <= '0;
      vtag_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      state_q     <= state_d;
      look_addr_q <= look_addr_d;
      wr_q        <= wr_d;
      tgt_q       <= tgt_d;
      vtag_q      <= vtag_d;
      age_q       <= age_d;
    end
  end

endmodule
